spike_event_encoder: RTL and testbench

Transmitter-side counterpart of the delayed-input LIF neuron datapath. Samples a layer's parallel spike vector (one `spike_out` per neuron) on each sample strobe and serialises every set bit into an address event (neuron index plus frame timestamp) over a valid/ready stream. The downstream consumer rebuilds `input_spikes` vectors for the next layer. Sits between a neuron layer's outputs and the inter-layer spike bus.

---
 rtl/snn_pkg.sv | 27 ++
 rtl/lowest_set_bit.sv | 27 ++
 rtl/spike_event_encoder.sv | 134 +++++++++++++
 tb/tb_spike_event_encoder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network layer interconnect: default widths
// and the address-event record exchanged between encoder and decoder.
package snn_pkg;

    localparam int SNN_N  = 8;
    localparam int SNN_AW = 3;
    localparam int SNN_TW = 4;

    typedef struct packed {
        logic [SNN_AW-1:0] addr;
        logic [SNN_TW-1:0] tstamp;
        logic              last;
    } spike_event_t;

    function automatic spike_event_t pack_event(
        input logic [SNN_AW-1:0] addr,
        input logic [SNN_TW-1:0] tstamp,
        input logic              last
    );
        spike_event_t ev;
        ev.addr   = addr;
        ev.tstamp = tstamp;
        ev.last   = last;
        return ev;
    endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// N-bit priority encoder: index and one-hot of the lowest set bit, plus a flag
// telling whether exactly one bit is set.
module lowest_set_bit import snn_pkg::*; #(
    parameter int N  = SNN_N,
    parameter int AW = SNN_AW
) (
    input  logic [N-1:0]  vec,
    output logic [AW-1:0] idx,
    output logic [N-1:0]  onehot,
    output logic          single
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = vec[i] ? AW'(i) : idx;
        end
    end

    // Two's-complement trick isolates the lowest set bit.
    always_comb begin
        onehot = vec & (~vec + N'(1));
        single = (vec != '0) && ((vec & (vec - N'(1))) == '0);
    end

endmodule

// File: rtl/spike_event_encoder.sv
// Serialises a sampled spike vector into address events (neuron index + frame
// timestamp) over a valid/ready stream, with a one-deep frame buffer behind it.
module spike_event_encoder import snn_pkg::*; #(
    parameter int N  = SNN_N,
    parameter int AW = SNN_AW,
    parameter int TW = SNN_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          sample,
    input  logic [N-1:0]  spikes_in,
    output logic          event_valid,
    input  logic          event_ready,
    output logic [AW-1:0] event_addr,
    output logic [TW-1:0] event_tstamp,
    output logic          event_last,
    output logic          overflow,
    output logic          busy
);

    logic [N-1:0]  work_q, work_d;
    logic [TW-1:0] work_ts_q, work_ts_d;
    logic [N-1:0]  buf_q, buf_d;
    logic [TW-1:0] buf_ts_q, buf_ts_d;
    logic          buf_full_q, buf_full_d;
    logic [TW-1:0] frame_cnt_q, frame_cnt_d;
    logic          overflow_q, overflow_d;

    logic [AW-1:0] lsb_idx_s;
    logic [N-1:0]  lsb_onehot_s;
    logic          lsb_single_s;
    logic          work_nz_s;
    logic          hs_s;
    logic          accept_s;
    logic          new_frame_s;
    logic [N-1:0]  work_rem_s;

    lowest_set_bit #(
        .N  (N),
        .AW (AW)
    ) u_lsb (
        .vec    (work_q),
        .idx    (lsb_idx_s),
        .onehot (lsb_onehot_s),
        .single (lsb_single_s)
    );

    // Next-state: retire the current event, then route buffer and new frame.
    always_comb begin
        work_d      = work_q;
        work_ts_d   = work_ts_q;
        buf_d       = buf_q;
        buf_ts_d    = buf_ts_q;
        buf_full_d  = buf_full_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q;

        work_nz_s   = (work_q != '0);
        hs_s        = work_nz_s && event_ready;
        work_rem_s  = hs_s ? (work_q & ~lsb_onehot_s) : work_q;
        accept_s    = sample && enable;
        new_frame_s = accept_s && (spikes_in != '0);

        if (accept_s) begin
            frame_cnt_d = frame_cnt_q + TW'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end

        work_d = work_rem_s;
        if ((work_rem_s == '0) && buf_full_q) begin
            // Buffer refills work on the same edge; a new frame takes its place.
            work_d     = buf_q;
            work_ts_d  = buf_ts_q;
            buf_full_d = new_frame_s;
            if (new_frame_s) begin
                buf_d    = spikes_in;
                buf_ts_d = frame_cnt_q;
            end else begin
                buf_d    = buf_q;
            end
        end else if (work_rem_s == '0) begin
            if (new_frame_s) begin
                work_d    = spikes_in;
                work_ts_d = frame_cnt_q;
            end else begin
                work_d    = work_rem_s;
            end
        end else if (!buf_full_q) begin
            if (new_frame_s) begin
                buf_d      = spikes_in;
                buf_ts_d   = frame_cnt_q;
                buf_full_d = 1'b1;
            end else begin
                buf_full_d = 1'b0;
            end
        end else begin
            overflow_d = overflow_q | new_frame_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q      <= '0;
            work_ts_q   <= '0;
            buf_q       <= '0;
            buf_ts_q    <= '0;
            buf_full_q  <= 1'b0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            work_q      <= work_d;
            work_ts_q   <= work_ts_d;
            buf_q       <= buf_d;
            buf_ts_q    <= buf_ts_d;
            buf_full_q  <= buf_full_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // Outputs depend only on registered state; idle fields are forced to zero.
    always_comb begin
        event_valid  = (work_q != '0);
        event_addr   = event_valid ? lsb_idx_s : '0;
        event_tstamp = event_valid ? work_ts_q : '0;
        event_last   = event_valid && lsb_single_s;
        overflow     = overflow_q;
        busy         = (work_q != '0) || buf_full_q;
    end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed self-checking bench for spike_event_encoder.
module tb_spike_event_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       sample;
    logic [7:0] spikes_in;
    logic       event_valid;
    logic       event_ready;
    logic [2:0] event_addr;
    logic [3:0] event_tstamp;
    logic       event_last;
    logic       overflow;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    spike_event_encoder #(.N(8), .AW(3), .TW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample       (sample),
        .spikes_in    (spikes_in),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_addr   (event_addr),
        .event_tstamp (event_tstamp),
        .event_last   (event_last),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares {valid, addr, tstamp, last} as one packed value.
    task automatic ev(input string tag, input logic v, input logic [2:0] a,
                      input logic [3:0] t, input logic l);
        chk(tag, {23'd0, event_valid, event_addr, event_tstamp, event_last},
                 {23'd0, v, a, t, l});
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; sample = 1'b0; spikes_in = 8'h00; event_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        ev("reset_ev", 1'b0, 3'd0, 4'd0, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ovf", overflow, 1'b0);

        // Frame A6 drained at full rate
        event_ready = 1'b1; sample = 1'b1; spikes_in = 8'hA6;
        tick(); sample = 1'b0;
        ev("a6_e0", 1'b1, 3'd1, 4'd0, 1'b0);
        chk("a6_busy", busy, 1'b1);
        tick(); ev("a6_e1", 1'b1, 3'd2, 4'd0, 1'b0);
        tick(); ev("a6_e2", 1'b1, 3'd5, 4'd0, 1'b0);
        tick(); ev("a6_e3", 1'b1, 3'd7, 4'd0, 1'b1);
        tick(); ev("a6_idle", 1'b0, 3'd0, 4'd0, 1'b0);
        chk("a6_busy_end", busy, 1'b0);

        // Frame 81 under backpressure
        event_ready = 1'b0; sample = 1'b1; spikes_in = 8'h81;
        tick(); sample = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ev("bp_hold", 1'b1, 3'd0, 4'd1, 1'b0);
            tick();
        end
        ev("bp_hold_end", 1'b1, 3'd0, 4'd1, 1'b0);
        event_ready = 1'b1;
        tick(); ev("bp_e1", 1'b1, 3'd7, 4'd1, 1'b1);
        tick(); ev("bp_idle", 1'b0, 3'd0, 4'd0, 1'b0);

        // Three back-to-back frames: two stored, third dropped
        reset = 1'b1; tick(); reset = 1'b0;
        event_ready = 1'b0; sample = 1'b1;
        spikes_in = 8'h01; tick();
        spikes_in = 8'h02; tick();
        spikes_in = 8'h04; tick();
        sample = 1'b0;
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_busy", busy, 1'b1);
        ev("ovf_f0", 1'b1, 3'd0, 4'd0, 1'b1);
        event_ready = 1'b1;
        tick(); ev("ovf_f1", 1'b1, 3'd1, 4'd1, 1'b1);
        tick(); ev("ovf_idle", 1'b0, 3'd0, 4'd0, 1'b0);
        chk("ovf_busy_end", busy, 1'b0);
        sample = 1'b1; spikes_in = 8'h08;
        tick(); sample = 1'b0;
        ev("ovf_gap", 1'b1, 3'd3, 4'd3, 1'b1);
        tick(); chk("ovf_sticky", overflow, 1'b1);

        // Sixteen zero frames wrap the timestamp
        reset = 1'b1; tick(); reset = 1'b0;
        chk("zero_ovf_clr", overflow, 1'b0);
        sample = 1'b1; spikes_in = 8'h00;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("zero_busy", busy, 1'b0);
            chk("zero_valid", event_valid, 1'b0);
        end
        spikes_in = 8'h40;
        tick(); sample = 1'b0;
        ev("zero_wrap", 1'b1, 3'd6, 4'd0, 1'b1);
        tick(); ev("zero_idle", 1'b0, 3'd0, 4'd0, 1'b0);

        // Buffer handoff on the last handshake, with a simultaneous new frame
        event_ready = 1'b0; sample = 1'b1;
        spikes_in = 8'h20; tick();
        spikes_in = 8'h03; tick();
        sample = 1'b0;
        ev("hand_w", 1'b1, 3'd5, 4'd1, 1'b1);
        event_ready = 1'b1; sample = 1'b1; spikes_in = 8'h10;
        tick(); sample = 1'b0;
        ev("hand_b0", 1'b1, 3'd0, 4'd2, 1'b0);
        tick(); ev("hand_b1", 1'b1, 3'd1, 4'd2, 1'b1);
        tick(); ev("hand_n", 1'b1, 3'd4, 4'd3, 1'b1);
        tick(); ev("hand_idle", 1'b0, 3'd0, 4'd0, 1'b0);

        // New frame on a last handshake with the buffer empty
        sample = 1'b1; spikes_in = 8'h01; tick();
        ev("direct_w", 1'b1, 3'd0, 4'd4, 1'b1);
        spikes_in = 8'h02; tick(); sample = 1'b0;
        ev("direct_n", 1'b1, 3'd1, 4'd5, 1'b1);
        tick(); ev("direct_idle", 1'b0, 3'd0, 4'd0, 1'b0);

        // enable=0 ignores sample and leaves the count alone
        enable = 1'b0; sample = 1'b1; spikes_in = 8'h55;
        tick(); sample = 1'b0;
        ev("dis_ign", 1'b0, 3'd0, 4'd0, 1'b0);
        chk("dis_busy", busy, 1'b0);
        enable = 1'b1;

        // Reset mid-frame with buffer full and overflow set
        event_ready = 1'b0; sample = 1'b1;
        spikes_in = 8'hFF; tick();
        spikes_in = 8'h0F; tick();
        spikes_in = 8'hF0; tick();
        sample = 1'b0;
        chk("mid_ovf", overflow, 1'b1);
        ev("mid_work", 1'b1, 3'd0, 4'd6, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        ev("mid_rst", 1'b0, 3'd0, 4'd0, 1'b0);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);

        // Draining continues with enable low
        event_ready = 1'b1; sample = 1'b1; spikes_in = 8'h0C;
        tick(); sample = 1'b0; enable = 1'b0;
        ev("post_e0", 1'b1, 3'd2, 4'd0, 1'b0);
        tick(); ev("post_e1", 1'b1, 3'd3, 4'd0, 1'b1);
        tick(); ev("post_idle", 1'b0, 3'd0, 4'd0, 1'b0);
        chk("post_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
